// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and opcode width shared by the ALU pipeline and its core.
package alu_pkg;
   localparam int OP_W = 3;
   typedef enum logic [OP_W-1:0] {
      OP_AND   = 3'b000,
      OP_OR    = 3'b001,
      OP_XOR   = 3'b010,
      OP_NOR   = 3'b011,
      OP_XNOR  = 3'b100,
      OP_ADD   = 3'b101,
      OP_SUB   = 3'b110,
      OP_PASSA = 3'b111
   } alu_op_t;
endpackage

// File: rtl/alu_logic_core.sv
// alu_logic_core: combinational opcode-selected ALU datapath with status flags.
// Ports: a, b operands; op opcode; y result; zero (y == 0); carry (ADD carry-out /
// SUB no-borrow); ovf signed overflow; illegal (opcode not built).
// Macro ALU_ARITH_EN: when defined ADD/SUB are implemented, otherwise they are
// reported illegal with y = 0 and no adder is built.
module alu_logic_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_t          op,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             carry,
   output logic             ovf,
   output logic             illegal
);
   logic w_arith;
   assign w_arith = (op == OP_ADD) || (op == OP_SUB);
`ifdef ALU_ARITH_EN
   logic [WIDTH-1:0] w_bx;
   logic [WIDTH:0]   w_sum;
   // SUB is a + ~b + 1, so one adder serves both; the +1 is the carry-in
   assign w_bx    = (op == OP_SUB) ? ~b : b;
   assign w_sum   = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, op == OP_SUB};
   assign carry   = w_arith && w_sum[WIDTH];
   // Overflow: both adder inputs share a sign that the result does not
   assign ovf     = w_arith && (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
   assign illegal = 1'b0;
`else
   assign carry   = 1'b0;
   assign ovf     = 1'b0;
   assign illegal = w_arith;
`endif
   always_comb begin
      y = '0;
      case (op)
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_XOR:   y = a ^ b;
         OP_NOR:   y = ~(a | b);
         OP_XNOR:  y = ~(a ^ b);
         OP_PASSA: y = a;
`ifdef ALU_ARITH_EN
         OP_ADD, OP_SUB: y = w_sum[WIDTH-1:0];
`endif
         default:  y = '0;
      endcase
   end
   assign zero = (y == '0);
endmodule

// File: rtl/alu_logic_pipe.sv
// alu_logic_pipe: two-stage valid/ready pipelined ALU (S1 operand register, S2 result register).
// Ports: clk, rst (async, active-high); in_valid/in_ready with a, b, op input handshake;
// out_valid/out_ready with y, zero, carry, ovf, illegal registered outputs.
// Macro ALU_ARITH_EN (in alu_logic_core) enables ADD/SUB; pipeline timing is unchanged either way.
module alu_logic_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             carry,
   output logic             ovf,
   output logic             illegal
);
   logic             r_s1_valid, r_s2_valid;
   logic [WIDTH-1:0] r_a, r_b, r_y;
   alu_op_t          r_op;
   logic             r_zero, r_carry, r_ovf, r_illegal;
   logic [WIDTH-1:0] w_y;
   logic             w_zero, w_carry, w_ovf, w_illegal, w_adv2, w_in_xfer;
   // S1 moves on whenever S2 is empty or draining this cycle; out_ready reaches in_ready combinationally
   assign w_adv2    = r_s1_valid && (!r_s2_valid || out_ready);
   assign in_ready  = !r_s1_valid || w_adv2;
   assign w_in_xfer = in_valid && in_ready;
   alu_logic_core #(.WIDTH(WIDTH)) u_core (
      .a       (r_a),
      .b       (r_b),
      .op      (r_op),
      .y       (w_y),
      .zero    (w_zero),
      .carry   (w_carry),
      .ovf     (w_ovf),
      .illegal (w_illegal)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= OP_AND;
      end else if (w_in_xfer) begin
         r_s1_valid <= 1'b1;
         r_a        <= a;
         r_b        <= b;
         r_op       <= alu_op_t'(op);
      end else if (w_adv2) begin
         r_s1_valid <= 1'b0;
      end
   end
   // Result registers only change on advance, so they hold while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_y        <= '0;
         r_zero     <= 1'b0;
         r_carry    <= 1'b0;
         r_ovf      <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (w_adv2) begin
         r_s2_valid <= 1'b1;
         r_y        <= w_y;
         r_zero     <= w_zero;
         r_carry    <= w_carry;
         r_ovf      <= w_ovf;
         r_illegal  <= w_illegal;
      end else if (out_ready) begin
         r_s2_valid <= 1'b0;
      end
   end
   assign out_valid = r_s2_valid;
   assign y         = r_y;
   assign zero      = r_zero;
   assign carry     = r_carry;
   assign ovf       = r_ovf;
   assign illegal   = r_illegal;
endmodule

// File: tb/tb_alu_logic_pipe.sv
// tb_alu_logic_pipe: randomized scoreboard bench for alu_logic_pipe against a behavioural ALU model.
module tb_alu_logic_pipe;
   import alu_pkg::*;
   localparam int W = 32;
   typedef struct packed {
      logic [W-1:0] y;
      logic         zero;
      logic         carry;
      logic         ovf;
      logic         illegal;
   } res_t;
   logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic         in_ready, out_valid, zero, carry, ovf, illegal;
   logic [W-1:0] a = '0, b = '0, y;
   logic [2:0]   op = '0;
   res_t         q[$];
   int           n_cmp = 0, n_err = 0;
   bit           mon_en = 1'b0;
   always #5 clk = ~clk;
   alu_logic_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .zero(zero), .carry(carry), .ovf(ovf), .illegal(illegal)
   );
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] z, input logic [2:0] o);
      res_t   r;
      longint sx, sz, s;
      sx = longint'($signed(x));
      sz = longint'($signed(z));
      r  = '0;
      case (o)
         3'd0: r.y = x & z;
         3'd1: r.y = x | z;
         3'd2: r.y = x ^ z;
         3'd3: r.y = ~(x | z);
         3'd4: r.y = ~(x ^ z);
         3'd7: r.y = x;
`ifdef ALU_ARITH_EN
         3'd5: begin
            r.y     = x + z;
            r.carry = (64'(x) + 64'(z)) >= (64'd1 << W);
            s       = sx + sz;
            r.ovf   = (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
         end
         3'd6: begin
            r.y     = x - z;
            r.carry = x >= z;
            s       = sx - sz;
            r.ovf   = (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
         end
`else
         default: r.illegal = 1'b1;
`endif
      endcase
      r.zero = (r.y == '0);
      return r;
   endfunction
   task automatic drive(input bit v, input logic [W-1:0] x, input logic [W-1:0] z,
                        input logic [2:0] o, input bit ordy, output bit acc);
      @(negedge clk);
      in_valid  = v;
      a         = x;
      b         = z;
      op        = o;
      out_ready = ordy;
      #1;
      acc = v && in_ready;
      if (acc) q.push_back(model(x, z, o));
   endtask
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] z, input logic [2:0] o);
      bit acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) drive(1'b1, x, z, o, 1'b1, acc);
      if (!acc) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready never accepted op %0d", o);
      end
   endtask
   task automatic idle(input int n, input bit ordy);
      bit acc;
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 3'd0, ordy, acc);
   endtask
   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction
   // Monitor: pops the scoreboard on every output transfer, checks stability while stalled
   initial begin
      bit   hold = 1'b0;
      res_t held, e;
      forever begin
         @(negedge clk);
         #2;
         if (!mon_en || rst) hold = 1'b0;
         else begin
            if (hold) begin
               chk("hold_valid", 64'(out_valid), 64'd1);
               chk("hold_data", 64'({y, zero, carry, ovf, illegal}), 64'(held));
            end
            hold = out_valid && !out_ready;
            held = {y, zero, carry, ovf, illegal};
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL spurious_output: got y=%0h with nothing expected", y);
               end else begin
                  e = q.pop_front();
                  chk("y", 64'(y), 64'(e.y));
                  chk("flags", 64'({zero, carry, ovf, illegal}), 64'({e.zero, e.carry, e.ovf, e.illegal}));
               end
            end
         end
      end
   end
   initial begin
      bit acc;
      int c;
      #12;
      chk("reset_outputs", 64'({out_valid, y, zero, carry, ovf, illegal}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      mon_en = 1'b1;
      // Latency: result appears after the second edge following transfer
      drive(1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'd2, 1'b1, acc);
      chk("lat_accept", 64'(acc), 64'd1);
      idle(1, 1'b1);
      chk("lat_not_yet", 64'(out_valid), 64'd0);
      idle(1, 1'b1);
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("lat_y", 64'(y), 64'hF0F0_0F0F);
      idle(2, 1'b1);
      send(32'hFFFF_FFFF, 32'd1, 3'd5);
      send(32'h7FFF_FFFF, 32'd1, 3'd5);
      send(32'd3, 32'd5, 3'd6);
      send(32'h8000_0000, 32'd1, 3'd6);
      send(32'd1, 32'd1, 3'd5);
      send(32'hF0, 32'h3C, 3'd0);
      idle(4, 1'b1);
      // Backpressure: two accepted while stalled, then in_ready drops
      c = 0;
      for (int k = 0; k < 4; ) begin
         drive(1'b1, 32'h100 + k, 32'h55, 3'(k), c >= 3, acc);
         if (c < 2) chk("bp_accept", 64'(acc), 64'd1);
         if (c == 2) chk("bp_full_in_ready", 64'(in_ready), 64'd0);
         if (acc) k++;
         c++;
         if (c > 40) break;
      end
      idle(4, 1'b1);
      // Randomized traffic with random backpressure
      for (int i = 0; i < 600; i++)
         drive($urandom_range(0, 3) != 0, pick(), pick(), 3'($urandom_range(0, 7)),
               $urandom_range(0, 3) != 0, acc);
      idle(6, 1'b1);
      // Reset with both stages full discards everything
      for (int i = 0; i < 3; i++) drive(1'b1, $urandom, $urandom, 3'd1, 1'b0, acc);
      drive(1'b0, '0, '0, 3'd0, 1'b0, acc);
      chk("full_before_reset", 64'({out_valid, in_ready}), 64'b10);
      mon_en = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midreset_out_valid", 64'(out_valid), 64'd0);
      chk("midreset_y", 64'(y), 64'd0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midreset_in_ready", 64'(in_ready), 64'd1);
      mon_en = 1'b1;
      send(32'h1234_5678, 32'h1234_5678, 3'd4);
      send(32'hA5A5_A5A5, 32'h0, 3'd7);
      for (int i = 0; i < 100 && q.size() != 0; i++) idle(1, 1'b1);
      idle(2, 1'b1);
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d results never emitted, expected 0 left", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/alu_logic_pipe.md
# alu_logic_pipe

Parametrised, two-stage pipelined ALU replacing single-function combinational units (fixed 32-bit XOR etc.) with one opcode-selected datapath. It accepts operand pairs through a valid/ready handshake, registers them, computes, and presents a registered result with status flags to the downstream consumer. Full backpressure lets it sit between any producer and consumer in the datapath at one operation per cycle.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  opcode (alu_pkg::alu_op_t)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- zero  out  1  y == 0
- carry  out  1  ADD carry-out / SUB no-borrow
- ovf  out  1  signed overflow (ADD/SUB)
- illegal  out  1  opcode not supported in this build

## Operation
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 XNOR, 101 ADD, 110 SUB, 111 PASSA (y = a).
- Logic ops and PASSA: carry = 0, ovf = 0.
- ADD: {carry,y} = a + b (WIDTH+1-bit); ovf = (a[MSB]==b[MSB]) && (y[MSB]!=a[MSB]).
- SUB: {carry,y} = a + ~b + 1; carry = 1 means no borrow (a ≥ b unsigned); ovf = (a[MSB]!=b[MSB]) && (y[MSB]!=a[MSB]).
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- zero computed from final y for every opcode.
- Stage S1: registers a, b, op, s1_valid on input transfer (in_valid && in_ready).
- Stage S2: registers y and flags computed from S1 registers; s2_valid drives out_valid.
- adv2 = s1_valid && (!s2_valid || out_ready); in_ready = !s1_valid || adv2.
- Combinational path out_ready → in_ready is intended; no skid buffer.
- While out_valid && !out_ready, y and all flags hold stable.
- A bubble (s1_valid = 0) advancing into S2 clears s2_valid when S2 drains.

## Timing
- Reset (async assert, deassert synchronised upstream): s1_valid = 0, s2_valid = 0, y = 0, zero = 0, carry = 0, ovf = 0, illegal = 0; in_ready = 1 after reset.
- Latency: operands transferred at edge k → out_valid high after edge k+1 with result.
- Throughput: 1 op/cycle with out_ready held high.
- Full (both stages valid, out_ready = 0): in_ready = 0, nothing overwritten.
- Simultaneous output transfer and input transfer in full state: S2 takes S1, S1 takes new input same edge; no bubble.
- Reset mid-stream: in-flight operations discarded; no partial result emitted.

## Configuration
- ALU_ARITH_EN defined: ADD and SUB implemented as above; illegal always 0.
- Not defined: no adder in netlist; ADD/SUB produce y = 0, zero = 1, carry = 0, ovf = 0, illegal = 1; pipeline timing unchanged.

## Structure
- Package alu_pkg: alu_op_t enum (3-bit, values above), OP_W = 3 constant.
- Sub-module alu_logic_core: purely combinational, WIDTH parameter, inputs a, b, op, outputs y, zero, carry, ovf, illegal; instantiated between S1 and S2 registers. Pipeline/handshake logic stays in alu_logic_pipe.

## Test plan
- WIDTH=32, out_ready=1, XOR a=0xFFFF0000 b=0x0F0F0F0F → y=0xF0F00F0F two edges after transfer, zero=0.
- ADD a=0xFFFFFFFF b=1 → y=0, zero=1, carry=1, ovf=0; ADD a=0x7FFFFFFF b=1 → y=0x80000000, ovf=1.
- SUB a=3 b=5 → y=0xFFFFFFFE, carry=0, ovf=0; SUB a=0x80000000 b=1 → y=0x7FFFFFFF, ovf=1.
- Backpressure: 4 back-to-back ops, out_ready=0 for 3 cycles → in_ready drops after 2 accepted, y stable, all 4 results emitted in order, none lost or duplicated.
- Assert rst with both stages full → out_valid=0, y=0 immediately; in_ready=1 after release.
- Build without ALU_ARITH_EN: ADD a=1 b=1 → y=0, zero=1, illegal=1; AND a=0xF0 b=0x3C → y=0x30, illegal=0.
